// File: rtl/fb_capture_ctrl_pkg.sv
// fb_capture_ctrl_pkg: shared frame geometry defaults and capture FSM encoding
package fb_capture_ctrl_pkg;

    localparam int c_img_cols_dflt = 160;
    localparam int c_img_rows_dflt = 120;
    localparam int c_nb_buf_dflt   = 12;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        WAIT_SOF,
        CAPTURE
    } fb_state_e;

endpackage

// File: rtl/sig_edge_det.sv
// sig_edge_det: one-cycle delay register with rise/fall strobes
module sig_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);

    logic sig_q;

    // remember last cycle's level so edges can be seen against it
    always_ff @(posedge clk) begin
        if (rst) sig_q <= 1'b0;
        else     sig_q <= sig_i;
    end

    assign rise_o = sig_i & ~sig_q;
    assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/fb_capture_ctrl.sv
// fb_capture_ctrl: turns a camera pixel stream into frame buffer write strobes
module fb_capture_ctrl
    import fb_capture_ctrl_pkg::*;
#(
    parameter  int c_img_cols    = c_img_cols_dflt,
    parameter  int c_img_rows    = c_img_rows_dflt,
    parameter  int c_nb_buf      = c_nb_buf_dflt,
    localparam int c_img_pxls    = c_img_cols * c_img_rows,
    localparam int c_nb_img_pxls = $clog2(c_img_pxls),
    localparam int c_nb_cols     = $clog2(c_img_cols + 1),
    localparam int c_nb_rows     = $clog2(c_img_rows + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     continuous,
    input  logic                     vsync,
    input  logic                     href,
    input  logic                     pxl_vld,
    input  logic [c_nb_buf-1:0]      pxl_rgb,
    output logic                     fb_wea,
    output logic [c_nb_img_pxls-1:0] fb_addra,
    output logic [c_nb_buf-1:0]      fb_dina,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     frame_err
);

    localparam logic [c_nb_cols-1:0] c_cols_w = c_nb_cols'(c_img_cols);
    localparam logic [c_nb_rows-1:0] c_rows_w = c_nb_rows'(c_img_rows);

    logic vsync_rise, vsync_fall, href_fall, href_rise_unused;

    sig_edge_det u_vsync_edge (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (vsync),
        .rise_o (vsync_rise),
        .fall_o (vsync_fall)
    );

    sig_edge_det u_href_edge (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (href),
        .rise_o (href_rise_unused),
        .fall_o (href_fall)
    );

    fb_state_e               state_q;
    logic [c_nb_img_pxls-1:0] addr_q;
    logic [c_nb_cols-1:0]     col_q;
    logic [c_nb_rows-1:0]     row_q;
    logic                     err_q;

    logic                 pxl_acc, in_range, err_d, frame_ok;
    logic [c_nb_rows-1:0] row_d, row_eff;

    // row end is resolved before frame end so a coincident href fall counts
    assign pxl_acc  = (state_q == CAPTURE) & href & pxl_vld & ~vsync;
    assign in_range = (col_q < c_cols_w) & (row_q < c_rows_w);
    assign row_d    = (row_q == c_rows_w) ? row_q : row_q + 1'b1;
    assign row_eff  = href_fall ? row_d : row_q;
    assign err_d    = err_q | (href_fall & (col_q != c_cols_w));
    assign frame_ok = (row_eff == c_rows_w) & ~err_d;

    // capture FSM with frame counters and registered write-port outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            col_q      <= '0;
            row_q      <= '0;
            err_q      <= 1'b0;
            fb_wea     <= 1'b0;
            fb_addra   <= '0;
            fb_dina    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            fb_wea     <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    state_q <= ARM;
                    busy    <= 1'b1;
                end
                ARM: if (vsync) state_q <= WAIT_SOF;
                WAIT_SOF: if (vsync_fall) begin
                    state_q <= CAPTURE;
                    addr_q  <= '0;
                    col_q   <= '0;
                    row_q   <= '0;
                    err_q   <= 1'b0;
                end
                CAPTURE: begin
                    if (pxl_acc && in_range) begin
                        fb_wea   <= 1'b1;
                        fb_addra <= addr_q;
                        fb_dina  <= pxl_rgb;
                        addr_q   <= addr_q + 1'b1;
                        col_q    <= col_q + 1'b1;
                    end
                    if (pxl_acc && !in_range) err_q <= 1'b1;
                    if (href_fall) begin
                        col_q <= '0;
                        row_q <= row_d;
                        err_q <= err_d;
                    end
                    if (vsync_rise) begin
                        frame_done <= frame_ok;
                        frame_err  <= ~frame_ok;
                        state_q    <= continuous ? WAIT_SOF : IDLE;
                        busy       <= continuous;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_capture_ctrl.sv
// tb_fb_capture_ctrl: directed scenarios for the frame buffer capture controller
module tb_fb_capture_ctrl;

    localparam int COLS = 4;
    localparam int ROWS = 3;
    localparam int NB   = 12;
    localparam int NA   = 4;

    logic          clk = 1'b0, rst = 1'b1, start = 1'b0, continuous = 1'b0;
    logic          vsync = 1'b1, href = 1'b0, pxl_vld = 1'b0;
    logic [NB-1:0] pxl_rgb = '0;
    logic          fb_wea, busy, frame_done, frame_err;
    logic [NA-1:0] fb_addra;
    logic [NB-1:0] fb_dina;

    int n_cmp = 0, n_bad = 0, cyc = 0, done_cnt = 0, err_cnt = 0;
    int            pix_q[$];
    int            wr_c[$];
    logic [NA-1:0] wr_a[$];
    logic [NB-1:0] wr_d[$];

    fb_capture_ctrl #(.c_img_cols(COLS), .c_img_rows(ROWS), .c_nb_buf(NB)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .continuous (continuous),
        .vsync      (vsync),
        .href       (href),
        .pxl_vld    (pxl_vld),
        .pxl_rgb    (pxl_rgb),
        .fb_wea     (fb_wea),
        .fb_addra   (fb_addra),
        .fb_dina    (fb_dina),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fb_wea) begin
            wr_a.push_back(fb_addra);
            wr_d.push_back(fb_dina);
            wr_c.push_back(cyc);
        end
        if (frame_done) done_cnt++;
        if (frame_err) err_cnt++;
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic kick;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
    endtask

    task automatic send_frame(input int nrows, input int long_row, input int abort_at, input bit drop_cont);
        int idx = 0;
        vsync = 1'b1; href = 1'b0; pxl_vld = 1'b0;
        repeat (3) tick;
        vsync = 1'b0;
        repeat (2) tick;
        for (int r = 0; r < nrows; r++) begin
            href = 1'b1;
            for (int p = 0; p < ((r == long_row) ? 5 : 4); p++) begin
                if (idx == abort_at) begin
                    pxl_vld = 1'b0; href = 1'b0; rst = 1'b1;
                    tick;
                    return;
                end
                pxl_vld = 1'b1;
                pxl_rgb = NB'(idx);
                pix_q.push_back(cyc);
                tick;
                idx++;
            end
            href = 1'b0; pxl_vld = 1'b0;
            if (drop_cont) continuous = 1'b0;
            repeat (2) tick;
        end
        vsync = 1'b1;
        repeat (3) tick;
    endtask

    task automatic test_reset;
        rst = 1'b1; href = 1'b1; pxl_vld = 1'b1; pxl_rgb = 12'hABC;
        repeat (3) tick;
        n_cmp++;
        if ({fb_wea, fb_addra, fb_dina, busy, frame_done, frame_err} !== '0) begin
            n_bad++;
            $display("FAIL reset_outs: wea=%b addr=%0d data=%0h busy=%b done=%b err=%b, expected all 0",
                     fb_wea, fb_addra, fb_dina, busy, frame_done, frame_err);
        end
        rst = 1'b0; href = 1'b0; pxl_vld = 1'b0;
        repeat (3) tick;
        n_cmp++;
        if (busy !== 1'b0 || fb_wea !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_quiet: busy=%b wea=%b, expected 0 0", busy, fb_wea);
        end
    endtask

    task automatic test_clean_frame;
        int w0 = wr_a.size(), p0 = pix_q.size(), d0 = done_cnt, e0 = err_cnt;
        continuous = 1'b0;
        kick;
        send_frame(3, -1, -1, 1'b0);
        repeat (3) tick;
        n_cmp++;
        if (wr_a.size() - w0 !== 12) begin
            n_bad++;
            $display("FAIL clean_count: got %0d writes, expected 12", wr_a.size() - w0);
        end
        for (int i = 0; i < 12 && w0 + i < wr_a.size(); i++) begin
            n_cmp++;
            if (wr_a[w0+i] !== NA'(i) || wr_d[w0+i] !== NB'(i) || wr_c[w0+i] !== pix_q[p0+i] + 1) begin
                n_bad++;
                $display("FAIL clean_wr[%0d]: addr=%0d data=%0d cyc=%0d, expected addr=%0d data=%0d cyc=%0d",
                         i, wr_a[w0+i], wr_d[w0+i], wr_c[w0+i], i, i, pix_q[p0+i] + 1);
            end
        end
        n_cmp++;
        if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL clean_end: done=%0d err=%0d busy=%b, expected 1 0 0", done_cnt - d0, err_cnt - e0, busy);
        end
    endtask

    task automatic test_start_mid_frame;
        int w0 = wr_a.size(), d0 = done_cnt, e0 = err_cnt;
        vsync = 1'b0; href = 1'b1; pxl_vld = 1'b1; pxl_rgb = 12'h100;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (3) tick;
        n_cmp++;
        if (busy !== 1'b1 || wr_a.size() != w0) begin
            n_bad++;
            $display("FAIL mid_armed: busy=%b writes=%0d, expected 1 0", busy, wr_a.size() - w0);
        end
        href = 1'b0; pxl_vld = 1'b0;
        repeat (2) tick;
        send_frame(3, -1, -1, 1'b0);
        repeat (3) tick;
        n_cmp++;
        if (wr_a.size() - w0 !== 12) begin
            n_bad++;
            $display("FAIL mid_count: got %0d writes, expected 12", wr_a.size() - w0);
        end
        for (int i = 0; i < 12 && w0 + i < wr_a.size(); i++) begin
            n_cmp++;
            if (wr_a[w0+i] !== NA'(i) || wr_d[w0+i] !== NB'(i)) begin
                n_bad++;
                $display("FAIL mid_wr[%0d]: addr=%0d data=%0h, expected addr=%0d data=%0h", i, wr_a[w0+i], wr_d[w0+i], i, i);
            end
        end
        n_cmp++;
        if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
            n_bad++;
            $display("FAIL mid_end: done=%0d err=%0d, expected 1 0", done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_long_row;
        int w0 = wr_a.size(), d0 = done_cnt, e0 = err_cnt;
        kick;
        send_frame(3, 1, -1, 1'b0);
        repeat (3) tick;
        n_cmp++;
        if (wr_a.size() - w0 !== 12) begin
            n_bad++;
            $display("FAIL long_count: got %0d writes, expected 12", wr_a.size() - w0);
        end
        for (int i = 0; i < 12 && w0 + i < wr_a.size(); i++) begin
            n_cmp++;
            if (wr_a[w0+i] !== NA'(i) || wr_d[w0+i] !== NB'((i < 8) ? i : i + 1)) begin
                n_bad++;
                $display("FAIL long_wr[%0d]: addr=%0d data=%0d, expected addr=%0d data=%0d",
                         i, wr_a[w0+i], wr_d[w0+i], i, (i < 8) ? i : i + 1);
            end
        end
        n_cmp++;
        if (done_cnt - d0 !== 0 || err_cnt - e0 !== 1) begin
            n_bad++;
            $display("FAIL long_end: done=%0d err=%0d, expected 0 1", done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_short_frame;
        int w0 = wr_a.size(), d0 = done_cnt, e0 = err_cnt;
        kick;
        send_frame(2, -1, -1, 1'b0);
        repeat (3) tick;
        n_cmp++;
        if (wr_a.size() - w0 !== 8) begin
            n_bad++;
            $display("FAIL short_count: got %0d writes, expected 8", wr_a.size() - w0);
        end
        for (int i = 0; i < 8 && w0 + i < wr_a.size(); i++) begin
            n_cmp++;
            if (wr_a[w0+i] !== NA'(i)) begin
                n_bad++;
                $display("FAIL short_wr[%0d]: addr=%0d, expected %0d", i, wr_a[w0+i], i);
            end
        end
        n_cmp++;
        if (done_cnt - d0 !== 0 || err_cnt - e0 !== 1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL short_end: done=%0d err=%0d busy=%b, expected 0 1 0", done_cnt - d0, err_cnt - e0, busy);
        end
    endtask

    task automatic test_back_to_back;
        int w0 = wr_a.size(), d0 = done_cnt, e0 = err_cnt;
        continuous = 1'b1;
        kick;
        for (int f = 0; f < 2; f++) begin
            send_frame(3, -1, -1, 1'b0);
            n_cmp++;
            if (busy !== 1'b1 || done_cnt - d0 !== f + 1) begin
                n_bad++;
                $display("FAIL b2b_rearm[%0d]: busy=%b done=%0d, expected 1 %0d", f, busy, done_cnt - d0, f + 1);
            end
        end
        send_frame(3, -1, -1, 1'b1);
        repeat (3) tick;
        n_cmp++;
        if (wr_a.size() - w0 !== 36) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d writes, expected 36", wr_a.size() - w0);
        end
        for (int i = 0; i < 36 && w0 + i < wr_a.size(); i++) begin
            n_cmp++;
            if (wr_a[w0+i] !== NA'(i % 12) || wr_d[w0+i] !== NB'(i % 12)) begin
                n_bad++;
                $display("FAIL b2b_wr[%0d]: addr=%0d data=%0d, expected %0d %0d", i, wr_a[w0+i], wr_d[w0+i], i % 12, i % 12);
            end
        end
        n_cmp++;
        if (done_cnt - d0 !== 3 || err_cnt - e0 !== 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_end: done=%0d err=%0d busy=%b, expected 3 0 0", done_cnt - d0, err_cnt - e0, busy);
        end
    endtask

    task automatic test_reset_mid_frame;
        int w0 = wr_a.size(), d0 = done_cnt, e0 = err_cnt, w1;
        continuous = 1'b0;
        kick;
        send_frame(3, -1, 6, 1'b0);
        n_cmp++;
        if (fb_wea !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid: wea=%b busy=%b, expected 0 0", fb_wea, busy);
        end
        rst = 1'b0;
        repeat (4) tick;
        n_cmp++;
        if (wr_a.size() - w0 !== 6 || done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin
            n_bad++;
            $display("FAIL rst_partial: writes=%0d done=%0d err=%0d, expected 6 0 0",
                     wr_a.size() - w0, done_cnt - d0, err_cnt - e0);
        end
        w1 = wr_a.size();
        kick;
        send_frame(3, -1, -1, 1'b0);
        repeat (3) tick;
        n_cmp++;
        if (wr_a.size() - w1 !== 12) begin
            n_bad++;
            $display("FAIL rst_recap_count: got %0d writes, expected 12", wr_a.size() - w1);
        end
        for (int i = 0; i < 12 && w1 + i < wr_a.size(); i++) begin
            n_cmp++;
            if (wr_a[w1+i] !== NA'(i) || wr_d[w1+i] !== NB'(i)) begin
                n_bad++;
                $display("FAIL rst_recap_wr[%0d]: addr=%0d data=%0d, expected %0d %0d", i, wr_a[w1+i], wr_d[w1+i], i, i);
            end
        end
        n_cmp++;
        if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
            n_bad++;
            $display("FAIL rst_recap_end: done=%0d err=%0d, expected 1 0", done_cnt - d0, err_cnt - e0);
        end
    endtask

    initial begin
        test_reset;
        test_clean_frame;
        test_start_mid_frame;
        test_long_row;
        test_short_frame;
        test_back_to_back;
        test_reset_mid_frame;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
